// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the shift-add floating-point multiplier.
package fp_mul_pkg;

  // Mantissa width including hidden bit; nominal number of shift iterations.
  localparam int unsigned ITER_DEF = 24;

  // Width of the iteration counters (controller shadow count and datapath counter).
  localparam int unsigned CNT_W = 5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_TEST,
    S_ADD,
    S_SHIFT,
    S_CHECK,
    S_MULDONE,
    S_NORM,
    S_OUT,
    S_DONE
  } state_e;

  // Per-state control outputs toward the datapath and the top level.
  typedef struct packed {
    logic init;
    logic clear;
    logic load;
    logic shift;
    logic done_mul;
    logic out_en;
    logic done;
    logic busy;
  } ctrl_t;

  // Moore decode of the control outputs for a given state.
  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c      = '0;
    c.busy = (s != S_IDLE);
    case (s)
      S_INIT: begin
        c.init  = 1'b1;
        c.clear = 1'b1;
      end
      S_ADD:     c.load     = 1'b1;
      S_SHIFT:   c.shift    = 1'b1;
      S_MULDONE: c.done_mul = 1'b1;
      S_OUT:     c.out_en   = 1'b1;
      S_DONE:    c.done     = 1'b1;
      default:   c          = c;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fp_mul_controller.sv
// Sequencing FSM for the shift-add floating-point multiplier datapath.
// Control outputs are registered from the next-state decode, so they line up
// cycle-for-cycle with the state they belong to while staying glitch-free.
module fp_mul_controller
  import fp_mul_pkg::*;
#(
  parameter int unsigned ITER = ITER_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic done_counter,
  input  logic lsb,
  input  logic msb,
  input  logic ovf,
  output logic init,
  output logic clear,
  output logic load,
  output logic shift,
  output logic done_mul,
  output logic out_en,
  output logic bit47,
  output logic busy,
  output logic done,
  output logic ovf_o,
  output logic seq_err
);

  localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(ITER);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit47_q, bit47_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  // State, shadow count, captured flags and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      bit47_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      bit47_q <= bit47_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic plus updates of the count, captured flags and error.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit47_d = bit47_q;
    ovf_d   = ovf_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        bit47_d = 1'b0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
        state_d = S_TEST;
      end
      S_TEST: begin
        state_d = lsb ? S_ADD : S_SHIFT;
      end
      S_ADD: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // The datapath counter and the shadow count must agree on the last iteration.
        if (done_counter != (cnt_q == ITER_CNT)) err_d = 1'b1;
        if (done_counter) begin
          state_d = S_MULDONE;
        end else if (cnt_q == CNT_MAX) begin
          // Counter never fired: bail out rather than hang.
          err_d   = 1'b1;
          state_d = S_MULDONE;
        end else begin
          state_d = S_TEST;
        end
      end
      S_MULDONE: begin
        bit47_d = msb;
        state_d = S_NORM;
      end
      S_NORM: begin
        state_d = S_OUT;
      end
      S_OUT: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        ovf_d   = ovf;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ctrl_d = decode_ctrl(state_d);
  end

  assign init     = ctrl_q.init;
  assign clear    = ctrl_q.clear;
  assign load     = ctrl_q.load;
  assign shift    = ctrl_q.shift;
  assign done_mul = ctrl_q.done_mul;
  assign out_en   = ctrl_q.out_en;
  assign done     = ctrl_q.done;
  assign busy     = ctrl_q.busy;
  assign bit47    = bit47_q;
  assign ovf_o    = ovf_q;
  assign seq_err  = err_q;

endmodule
